chess_clock_ctrl: RTL

//  Two-player chess clock sequencer that drives the 32-bit reg_a word of the timer seven-seg display.

---
 rtl/chess_clock_pkg.sv | 83 ++++++++
 rtl/bcd_mmss_counter.sv | 49 ++++
 rtl/chess_clock_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/chess_clock_pkg.sv
// Shared types and BCD helpers for the two-player chess clock.
// Optional feature macro: CHESS_CLK_INC_EN (per-move increment helper).
package chess_clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        TIMEOUT
    } state_t;

    // One side's time, packed BCD mm:ss, most significant digit first.
    typedef struct packed {
        logic [3:0] mm_t;
        logic [3:0] mm_o;
        logic [3:0] ss_t;
        logic [3:0] ss_o;
    } mmss_t;

    localparam logic [15:0] MMSS_ZERO = 16'h0000;
    localparam logic [15:0] MMSS_ONE  = 16'h0001;
    localparam logic [15:0] MMSS_MAX  = 16'h9959;

    // A loadable time: every digit is decimal, seconds below 60, not 00:00.
    function automatic logic mmss_valid(input mmss_t v);
        return (v.mm_t <= 4'd9) && (v.mm_o <= 4'd9) &&
               (v.ss_t <= 4'd5) && (v.ss_o <= 4'd9) &&
               (v != MMSS_ZERO);
    endfunction

    // Subtract one second; ss 00 borrows from the minutes. Caller keeps v != 00:00.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r = v;
        if (v.ss_o != 4'd0) begin
            r.ss_o = v.ss_o - 4'd1;
        end else if (v.ss_t != 4'd0) begin
            r.ss_t = v.ss_t - 4'd1;
            r.ss_o = 4'd9;
        end else begin
            r.ss_t = 4'd5;
            r.ss_o = 4'd9;
            if (v.mm_o != 4'd0) begin
                r.mm_o = v.mm_o - 4'd1;
            end else begin
                r.mm_t = v.mm_t - 4'd1;
                r.mm_o = 4'd9;
            end
        end
        return r;
    endfunction

`ifdef CHESS_CLK_INC_EN
    // Add 0..59 seconds (BCD tens/ones) with carry into minutes, saturating at 99:59.
    function automatic mmss_t mmss_add_sec(input mmss_t v, input logic [3:0] inc_t,
                                           input logic [3:0] inc_o);
        mmss_t      r = v;
        logic [4:0] so;
        logic [4:0] st;
        logic       c_s;
        logic       c_min;
        so  = {1'b0, v.ss_o} + {1'b0, inc_o};
        c_s = (so > 5'd9);
        if (c_s) so = so - 5'd10;
        st    = {1'b0, v.ss_t} + {1'b0, inc_t} + {4'd0, c_s};
        c_min = (st > 5'd5);
        if (c_min) st = st - 5'd6;
        r.ss_o = so[3:0];
        r.ss_t = st[3:0];
        if (c_min) begin
            if ((v.mm_t == 4'd9) && (v.mm_o == 4'd9)) begin
                r = MMSS_MAX;
            end else if (v.mm_o == 4'd9) begin
                r.mm_o = 4'd0;
                r.mm_t = v.mm_t + 4'd1;
            end else begin
                r.mm_o = v.mm_o + 4'd1;
            end
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/bcd_mmss_counter.sv
// One side of the chess clock: a BCD mm:ss down-counter with load and,
// when CHESS_CLK_INC_EN is defined, a saturating per-move increment.
module bcd_mmss_counter
    import chess_clock_pkg::*;
#(
    parameter logic [15:0] INIT_MMSS = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
`ifdef CHESS_CLK_INC_EN
    input  logic        inc,
    input  logic [7:0]  inc_bcd,
`endif
    output logic [15:0] value,
    output logic        is_zero
);

    mmss_t cur;
    mmss_t nxt;

    assign cur     = value;
    assign is_zero = (value == MMSS_ZERO);

    // Next value: load wins, otherwise decrement first and then add the increment.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else begin
            if (dec && !is_zero) nxt = mmss_dec(cur);
`ifdef CHESS_CLK_INC_EN
            // A side that just reached 00:00 has lost; it gets no increment.
            if (inc && (nxt != MMSS_ZERO)) nxt = mmss_add_sec(nxt, inc_bcd[7:4], inc_bcd[3:0]);
`endif
        end
    end

    // Time register, reset to the configured starting time.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) value <= INIT_MMSS;
        else       value <= nxt;
    end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock sequencer driving the display word reg_a.
// Holds the run/pause/timeout FSM, the 1 s prescaler, turn logic and output register.
// Optional feature macro: CHESS_CLK_INC_EN (adds INC_SEC to the mover on each move).
module chess_clock_ctrl
    import chess_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter logic [15:0] INIT_MMSS = 16'h1000,
    parameter logic [7:0]  INC_SEC   = 8'd5
) (
    input  logic        segclk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] init_mmss,
    input  logic        start,
    input  logic        move_done,
    input  logic        pause,
    output logic [31:0] reg_a,
    output logic        turn_b,
    output logic        running,
    output logic        timeout_w,
    output logic        timeout_b,
    output logic        load_err
);

    localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [15:0]   white_val;
    logic [15:0]   black_val;
    logic          white_zero;
    logic          black_zero;
    logic          load_ok;
    logic          tick;
    logic          expire;
    logic          move_ok;
    logic          active_zero;
    logic [15:0]   active_val;

    // A rejected load only raises load_err; the other inputs of that cycle still act.
    assign load_ok     = load && mmss_valid(init_mmss);
    assign tick        = (state == RUN) && (presc == PRESC_LAST);
    assign active_val  = turn_b ? black_val : white_val;
    assign active_zero = turn_b ? black_zero : white_zero;
    // The side to move reaches 00:00 on this tick.
    assign expire      = tick && (active_val == MMSS_ONE);
    // Hand-over: pause beats move_done, and a flag falling in the same cycle beats both.
    assign move_ok     = (state == RUN) && move_done && !pause && !expire && !load_ok;
    assign running     = (state == RUN);

`ifdef CHESS_CLK_INC_EN
    localparam logic [7:0] INC_BCD = {4'(INC_SEC / 8'd10), 4'(INC_SEC % 8'd10)};
    logic inc_w;
    logic inc_b;
    assign inc_w = move_ok && !turn_b;
    assign inc_b = move_ok && turn_b;
`else
    localparam logic [7:0] UNUSED_INC_SEC = INC_SEC;
`endif

    bcd_mmss_counter #(.INIT_MMSS(INIT_MMSS)) u_white (
        .clk      (segclk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (init_mmss),
        .dec      (tick && !turn_b),
`ifdef CHESS_CLK_INC_EN
        .inc      (inc_w),
        .inc_bcd  (INC_BCD),
`endif
        .value    (white_val),
        .is_zero  (white_zero)
    );

    bcd_mmss_counter #(.INIT_MMSS(INIT_MMSS)) u_black (
        .clk      (segclk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (init_mmss),
        .dec      (tick && turn_b),
`ifdef CHESS_CLK_INC_EN
        .inc      (inc_b),
        .inc_bcd  (INC_BCD),
`endif
        .value    (black_val),
        .is_zero  (black_zero)
    );

    // Next-state logic; an accepted load returns to IDLE from any state.
    always_comb begin
        state_nxt = state;
        if (load_ok) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN: begin
                    if (expire || active_zero) state_nxt = TIMEOUT;
                    else if (pause)            state_nxt = PAUSED;
                end
                PAUSED:  if (pause) state_nxt = RUN;
                TIMEOUT: state_nxt = TIMEOUT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge segclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Prescaler: counts only while running, holds when paused, restarts each turn.
    always_ff @(posedge segclk) begin
        if (reset) begin
            presc <= '0;
        end else if (load_ok || ((state == IDLE) && start) || move_ok) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // Turn, sticky timeout flags and the load rejection pulse.
    always_ff @(posedge segclk) begin
        if (reset) begin
            turn_b    <= 1'b0;
            timeout_w <= 1'b0;
            timeout_b <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_err <= load && !mmss_valid(init_mmss);
            if (load_ok) begin
                turn_b    <= 1'b0;
                timeout_w <= 1'b0;
                timeout_b <= 1'b0;
            end else begin
                if ((state == IDLE) && start) turn_b <= 1'b0;
                else if (move_ok)             turn_b <= ~turn_b;
                if (expire && !turn_b) timeout_w <= 1'b1;
                if (expire && turn_b)  timeout_b <= 1'b1;
            end
        end
    end

    // Display word, one cycle behind the counters.
    always_ff @(posedge segclk) begin
        if (reset) reg_a <= {INIT_MMSS, INIT_MMSS};
        else       reg_a <= {white_val, black_val};
    end

endmodule
